irq_ctrl: RTL
=============

IRQ_CTRL -- requirements
Module: irq_ctrl

Interface
REQ-001 Parameters SHALL be:
- N_IRQ, default 8, number of interrupt sources, legal range 1..8.
- BASE, default 16'hd000, bus address of register 0; registers occupy BASE..BASE+3.
- VEC_TABLE, default 16'hff00, first byte of the per-channel vector table.
REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1, sole clock; all state updates on the rising edge.
- rst, in, 1, synchronous active-high reset.
- addr, in, 16, core address bus; carries the address one clock before data, matching the core's synchronous memory.
- data_i, in, 8, write data from the core.
- rw, in, 1, 1 = read, 0 = write.
- irq_src, in, N_IRQ, asynchronous interrupt request inputs.
- data_o, out, 8, registered read data.
- sel, out, 1, data_o is valid this cycle (register read or vector read).
- vec_hit, out, 1, data_o carries a vector byte this cycle.
- irq, out, 1, interrupt request to the core's irq input.
- active, out, 4, bit 3 = none pending; bits 2:0 = index of the highest-priority pending enabled channel.

Function
REQ-003 Each irq_src bit SHALL pass through a 2-flop synchronizer; s2 is the second stage and s2_d is s2 delayed one cycle.
REQ-004 Register map (offset = addr-BASE) SHALL be:
- 0 PEND: read; write-1-to-clear.
- 1 EN: read/write.
- 2 MODE: read/write; per bit, 1 = edge, 0 = level.
- 3 ACT: read-only, equals {4'b0, active}.
- Bits at or above N_IRQ read 0 and ignore writes.
REQ-005 Edge-mode PEND[i] SHALL set on (s2 & ~s2_d) and clear on a W1C write; when set and clear occur in the same cycle, set wins.
REQ-006 Level-mode PEND[i] SHALL be a register loaded from s2 each cycle; W1C writes have no effect on it.
REQ-007 Changing MODE[i] SHALL clear PEND[i] in the same write cycle.
REQ-008 Timing: irq_src[i] high sampled at edge k, with EN[i]=1, SHALL produce PEND[i]=1 and irq=1 after edge k+2.
REQ-009 irq SHALL equal |(PEND & EN), driven combinationally from registers.
REQ-010 Priority SHALL be fixed, with the lowest index highest; active SHALL be derived combinationally from PEND & EN.
REQ-011 A read with addr in BASE..BASE+3 presented in cycle n SHALL drive data_o with the register value and sel=1 in cycle n+1; in every other cycle sel=0 and data_o=0.
REQ-012 Writes SHALL take effect at the edge ending the cycle in which rw=0 and addr is in range; a write never asserts sel.
REQ-013 A read of ACT in the same cycle as a PEND change SHALL return the pre-change value.

Reset
REQ-014 While rst=1, the following SHALL all be 0: synchronizers, PEND, EN, MODE, data_o, sel, vec_hit, irq.
REQ-015 While rst=1, active SHALL read 4'b1000.
REQ-016 rst asserted mid-read SHALL suppress sel in the following cycle.
REQ-017 Edges arriving during reset SHALL be discarded.
REQ-018 The first edge detectable after reset release SHALL require s2 to rise after release.

Configuration
REQ-019 Macro IRQ_CTRL_VECTOR_EN, when defined, SHALL enable vectoring:
- A read of 16'hfffe in cycle n with active[3]=0 SHALL latch the active index into vidx.
- It SHALL drive data_o = low byte of (VEC_TABLE + 2*vidx) with sel=1 and vec_hit=1 in cycle n+1.
- A read of 16'hffff SHALL return the high byte using the latched vidx, so a request arriving between the two reads cannot split the vector.
- With active[3]=1, or when not compiled in, vector-address reads SHALL leave sel=0 and vec_hit=0, so the core's normal memory supplies the vector.
REQ-020 When IRQ_CTRL_VECTOR_EN is undefined, vec_hit SHALL be tied 0 and no vidx state SHALL exist.

Verification
REQ-021 Bench SHALL cover these directed scenarios (N_IRQ=8 unless stated):
- Reset, write EN=8'h04, MODE=8'h04, pulse irq_src[2] for one cycle at edge k -> irq=1 after k+2, PEND reads 8'h04, ACT reads 8'h02.
- W1C 8'h04 to PEND in the same cycle a new edge on channel 2 is detected -> PEND stays 8'h04.
- Level mode on channels 1 and 5, EN=8'h22, both held high -> ACT=8'h01; drop channel 1 -> ACT=8'h05 two cycles later; drop both -> irq=0, ACT=8'h08.
- IRQ_CTRL_VECTOR_EN, VEC_TABLE=16'hff00, channel 3 pending -> read fffe returns 8'h06 with vec_hit=1; raise channel 0, then read ffff -> returns 8'hff and vidx stays 3.
- Nothing pending, read fffe -> sel=0 and vec_hit=0; build without the macro -> vec_hit=0 always.
- Assert rst for one cycle during an ACT read -> sel=0 next cycle and all registers return 0.

Source files
------------

// File: rtl/irq_ctrl.sv
// irq_ctrl: synchronized interrupt sources, per-channel pend/enable/mode
// registers on a 4-byte bus window, and a fixed-priority active encoder.
// Optional vectoring on reads of 16'hfffe/16'hffff is built in when the
// macro IRQ_CTRL_VECTOR_EN is defined.
module irq_ctrl #(
  parameter int          N_IRQ     = 8,
  parameter logic [15:0] BASE      = 16'hd000,
  parameter logic [15:0] VEC_TABLE = 16'hff00
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [15:0]      addr,
  input  logic [7:0]       data_i,
  input  logic             rw,
  input  logic [N_IRQ-1:0] irq_src,
  output logic [7:0]       data_o,
  output logic             sel,
  output logic             vec_hit,
  output logic             irq,
  output logic [3:0]       active
);

  logic [N_IRQ-1:0] s1_q, s1_d, s2_q, s2_d, s2_dly_q, s2_dly_d;
  logic [N_IRQ-1:0] pend_q, pend_d, en_q, en_d, mode_q, mode_d;
  logic [N_IRQ-1:0] edge_c, w1c_c, mchg_c, wdata_c;
  logic [7:0]       data_o_q, data_o_d;
  logic             sel_q, sel_d;
  logic [15:0]      off_c;
  logic             in_rng_c, wr_en_c, rd_en_c;
  logic [3:0]       active_c;
  logic [7:0]       pend8_c, en8_c, mode8_c;

  assign off_c    = addr - BASE;
  assign in_rng_c = (off_c < 16'd4);
  assign wr_en_c  = ~rw & in_rng_c;
  assign rd_en_c  = rw & in_rng_c;
  assign wdata_c  = data_i[N_IRQ-1:0];

  // Zero-extend the narrow registers so unused upper bits read as 0.
  always_comb begin
    pend8_c = '0;
    en8_c   = '0;
    mode8_c = '0;
    pend8_c[N_IRQ-1:0] = pend_q;
    en8_c[N_IRQ-1:0]   = en_q;
    mode8_c[N_IRQ-1:0] = mode_q;
  end

  // Fixed priority: scan downward so the lowest pending enabled index wins.
  always_comb begin
    active_c = 4'b1000;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (pend_q[i] && en_q[i]) active_c = {1'b0, 3'(i)};
    end
    if (rst) active_c = 4'b1000;
  end

  assign active = active_c;
  assign irq    = (|(pend_q & en_q)) & ~rst;

  // Synchronizer chain, register writes and pend update.
  always_comb begin
    s1_d     = irq_src;
    s2_d     = s1_q;
    s2_dly_d = s2_q;
    edge_c   = s2_q & ~s2_dly_q;
    en_d     = en_q;
    mode_d   = mode_q;
    w1c_c    = '0;
    mchg_c   = '0;
    if (wr_en_c) begin
      case (off_c[1:0])
        2'd0: w1c_c = wdata_c;
        2'd1: en_d  = wdata_c;
        2'd2: begin
          mode_d = wdata_c;
          mchg_c = wdata_c ^ mode_q;
        end
        default: ;
      endcase
    end
    for (int i = 0; i < N_IRQ; i++) begin
      // Edge: set beats a simultaneous W1C. Level: mirror s2, ignore W1C.
      if (mode_q[i]) pend_d[i] = edge_c[i] | (pend_q[i] & ~w1c_c[i]);
      else           pend_d[i] = s2_q[i];
      if (mchg_c[i]) pend_d[i] = 1'b0;
    end
  end

`ifdef IRQ_CTRL_VECTOR_EN
  logic [2:0]  vidx_q, vidx_d;
  logic        vec_hit_q, vec_hit_d;
  logic [15:0] vlo_c, vhi_c;

  assign vlo_c   = VEC_TABLE + {12'b0, active_c[2:0], 1'b0};
  assign vhi_c   = VEC_TABLE + {12'b0, vidx_q, 1'b0};
  assign vec_hit = vec_hit_q;
`endif

  // Read path: register or vector byte, presented the cycle after the address.
  always_comb begin
    data_o_d = '0;
    sel_d    = 1'b0;
    if (rd_en_c) begin
      sel_d = 1'b1;
      case (off_c[1:0])
        2'd0:    data_o_d = pend8_c;
        2'd1:    data_o_d = en8_c;
        2'd2:    data_o_d = mode8_c;
        default: data_o_d = {4'b0, active_c};
      endcase
    end
`ifdef IRQ_CTRL_VECTOR_EN
    vidx_d    = vidx_q;
    vec_hit_d = 1'b0;
    // The low-byte read latches the index so the high byte cannot split.
    if (rw && addr == 16'hfffe && !active_c[3]) begin
      vidx_d    = active_c[2:0];
      data_o_d  = vlo_c[7:0];
      sel_d     = 1'b1;
      vec_hit_d = 1'b1;
    end
    if (rw && addr == 16'hffff && !active_c[3]) begin
      data_o_d  = vhi_c[15:8];
      sel_d     = 1'b1;
      vec_hit_d = 1'b1;
    end
`endif
  end

`ifndef IRQ_CTRL_VECTOR_EN
  assign vec_hit = 1'b0;
`endif

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q     <= '0;
      s2_q     <= '0;
      s2_dly_q <= '0;
      pend_q   <= '0;
      en_q     <= '0;
      mode_q   <= '0;
      data_o_q <= '0;
      sel_q    <= 1'b0;
`ifdef IRQ_CTRL_VECTOR_EN
      vidx_q    <= '0;
      vec_hit_q <= 1'b0;
`endif
    end else begin
      s1_q     <= s1_d;
      s2_q     <= s2_d;
      s2_dly_q <= s2_dly_d;
      pend_q   <= pend_d;
      en_q     <= en_d;
      mode_q   <= mode_d;
      data_o_q <= data_o_d;
      sel_q    <= sel_d;
`ifdef IRQ_CTRL_VECTOR_EN
      vidx_q    <= vidx_d;
      vec_hit_q <= vec_hit_d;
`endif
    end
  end

  assign data_o = data_o_q;
  assign sel    = sel_q;

endmodule
